gauss_ctrl: RTL

//  Frame sequencer for the Gaussian stage. Walks the image in 9-row bands and fetches one
//  9-pixel column per SRAM read through a request/grant port. Drives nineXnine_enable and

---
 rtl/gauss_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/gauss_ctrl.sv
// gauss_ctrl: frame sequencer for the Gaussian stage.
// Walks the image in 9-row bands (7 output rows per band), fetches one 9-pixel
// column per granted SRAM read, drives the column buffer shift into gauss_block
// and hands each 7-pixel result column to the writer.
// Optional build macro: GAUSS_CTRL_PERF_EN adds perf_cycles / perf_stalls counters.
module gauss_ctrl #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        cfg_shift,
   output logic              busy,
   output logic              done,
   output logic              rd_req,
   input  logic              rd_gnt,
   output logic [ADDR_W-1:0] rd_col,
   output logic [ADDR_W-1:0] rd_row_base,
   output logic              nineXnine_enable,
   output logic [1:0]        gauss_shift,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_col,
   output logic [ADDR_W-1:0] wr_row_base
`ifdef GAUSS_CTRL_PERF_EN
   ,
   output logic [31:0]       perf_cycles,
   output logic [31:0]       perf_stalls
`endif
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRIME = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_BAND  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [1:0]        shift_q, shift_d;
   logic              en_q, en_d;          // read data returns this cycle
   logic              en_run_q, en_run_d;  // ... and it belongs to a RUN read
   logic              wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0] wr_col_q, wr_col_d;
   logic              rd_xfer, wr_xfer;
   logic [ADDR_W:0]   next_band_end;

   assign busy             = (state_q != S_IDLE);
   assign done             = (state_q == S_DONE);
   assign rd_col           = col_q;
   assign rd_row_base      = row_base_q;
   // Gated by rst so a read in flight when reset arrives never shifts the buffer.
   assign nineXnine_enable = en_q & ~rst;
   assign gauss_shift      = shift_q;
   assign wr_valid         = wr_valid_q;
   assign wr_col           = wr_col_q;
   assign wr_row_base      = row_base_q;

   // Read request: PRIME streams cols 0..7; RUN issues a column only when no
   // data is returning and the previous result is gone or leaving this cycle.
   always_comb begin
      rd_req = 1'b0;
      case (state_q)
         S_PRIME: rd_req = 1'b1;
         S_RUN:   rd_req = !en_q && (!wr_valid_q || wr_ready) && (col_q < ADDR_W'(IMG_W));
         default: rd_req = 1'b0;
      endcase
   end

   assign rd_xfer       = rd_req && rd_gnt;
   assign wr_xfer       = wr_valid_q && wr_ready;
   assign next_band_end = {1'b0, row_base_q} + (ADDR_W+1)'(7 + 9);

   // Next-state, counters and result-column tracking.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_base_d = row_base_q;
      shift_d    = shift_q;
      en_d       = rd_xfer;
      en_run_d   = rd_xfer && (state_q == S_RUN);
      wr_valid_d = wr_valid_q;
      wr_col_d   = wr_col_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d    = cfg_shift;
               col_d      = '0;
               row_base_d = '0;
               state_d    = S_PRIME;
            end
         end
         S_PRIME: begin
            if (rd_xfer) begin
               col_d = col_q + 1'b1;
               if (col_q == ADDR_W'(7)) state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (rd_xfer) col_d = col_q + 1'b1;
            if (wr_xfer && (col_q == ADDR_W'(IMG_W))) state_d = S_BAND;
         end
         S_BAND: begin
            col_d = '0;
            if (next_band_end > (ADDR_W+1)'(IMG_H)) begin
               row_base_d = '0;
               state_d    = S_DONE;
            end else begin
               row_base_d = row_base_q + ADDR_W'(7);
               state_d    = S_PRIME;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Result appears the cycle after the buffer shift; col_q is already c+1.
      if (en_run_q) begin
         wr_valid_d = 1'b1;
         wr_col_d   = col_q - ADDR_W'(5);
      end else if (wr_xfer) begin
         wr_valid_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         col_q      <= '0;
         row_base_q <= '0;
         shift_q    <= '0;
         en_q       <= 1'b0;
         en_run_q   <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_col_q   <= '0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_base_q <= row_base_d;
         shift_q    <= shift_d;
         en_q       <= en_d;
         en_run_q   <= en_run_d;
         wr_valid_q <= wr_valid_d;
         wr_col_q   <= wr_col_d;
      end
   end

`ifdef GAUSS_CTRL_PERF_EN
   logic [31:0] cyc_q, cyc_d, stall_q, stall_d;
   logic        stall_now, start_acc;

   assign stall_now   = (rd_req && !rd_gnt) || (wr_valid_q && !wr_ready);
   assign start_acc   = (state_q == S_IDLE) && start;
   assign perf_cycles = cyc_q;
   assign perf_stalls = stall_q;

   // Saturating busy-cycle and stall-cycle counters, cleared on accepted start.
   always_comb begin
      cyc_d   = cyc_q;
      stall_d = stall_q;
      if (start_acc) begin
         cyc_d   = '0;
         stall_d = '0;
      end else begin
         if (busy && (cyc_q != '1))        cyc_d   = cyc_q + 1'b1;
         if (stall_now && (stall_q != '1)) stall_d = stall_q + 1'b1;
      end
   end

   // Perf counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q   <= '0;
         stall_q <= '0;
      end else begin
         cyc_q   <= cyc_d;
         stall_q <= stall_d;
      end
   end
`endif

endmodule
